// File: rtl/result_tx_pkg.sv
// Shared types and sizing helpers for the result-to-UART streamer.
package result_tx_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        HDR  = 3'd2,
        SEND = 3'd3,
        WAIT = 3'd4
    } state_t;

    function automatic int nb_of(input int data_w);
        return data_w / 8;
    endfunction

    // A one-byte word still needs a 1-bit byte counter.
    function automatic int cnt_w_of(input int data_w);
        return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
    endfunction

endpackage

// File: rtl/result_tx_ctrl_if.sv
// Result-word input stream plus UART byte handshake.
interface result_tx_ctrl_if #(
    parameter int DATA_W = 128
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_done;

    modport master (
        output in_data, in_valid, tx_done,
        input  in_ready, tx_start, tx_data
    );

    modport slave (
        input  in_data, in_valid, tx_done,
        output in_ready, tx_start, tx_data
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, occupancy count and synchronous clear.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_h,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic [AW:0]      count
);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW + 1)'(1);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == FULL_CNT);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst_h) begin
        if (rst_h) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)
                wr_ptr <= wr_ptr + ONE;
            if (rd_en && (count != '0))
                rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/result_tx_ctrl.sv
// Buffers result words and serialises them MSB-first into UART bytes,
// optionally preceded by a header byte, one tx_start strobe per byte.
module result_tx_ctrl
    import result_tx_pkg::*;
#(
    parameter int         DATA_W   = 128,
    parameter int         DEPTH    = 4,
    parameter bit         HDR_EN   = 1'b1,
    parameter logic [7:0] HDR_BYTE = 8'hA5,
    localparam int FW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_h,
    result_tx_ctrl_if.slave bus,
    input  logic          flush,
    output logic          busy,
    output logic [FW-1:0] fill_level,
    output logic          overflow
);
    localparam int             NB   = nb_of(DATA_W);
    localparam int             CW   = cnt_w_of(DATA_W);
    localparam logic [CW-1:0]  LAST = CW'(NB - 1);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              hdr_pend, hdr_pend_nxt;
    logic              done_q;
    logic              done_rise;
    logic              pop;
    logic              full;
    logic              wr_en;
    logic [DATA_W-1:0] rd_data;

    // A flush in the same cycle wins over the push; the word is silently dropped.
    assign wr_en        = bus.in_valid && !full && !flush;
    assign bus.in_ready = !full;
    assign done_rise    = bus.tx_done && !done_q;
    assign busy         = (state != IDLE);

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_h   (rst_h),
        .clr     (flush),
        .wr_en   (wr_en),
        .wr_data (bus.in_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .full    (full),
        .count   (fill_level)
    );

    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        cnt_nxt      = cnt;
        hdr_pend_nxt = hdr_pend;
        pop          = 1'b0;
        case (state)
            IDLE: if ((fill_level != '0) && bus.tx_done) state_nxt = LOAD;
            LOAD: begin
                // A flush racing IDLE->LOAD can leave nothing to pop.
                if (fill_level == '0) begin
                    state_nxt = IDLE;
                end else begin
                    pop          = 1'b1;
                    shreg_nxt    = rd_data;
                    cnt_nxt      = '0;
                    hdr_pend_nxt = HDR_EN;
                    state_nxt    = HDR_EN ? HDR : SEND;
                end
            end
            HDR:  state_nxt = WAIT;
            SEND: state_nxt = WAIT;
            WAIT: begin
                if (done_rise) begin
                    if (hdr_pend) begin
                        hdr_pend_nxt = 1'b0;
                        state_nxt    = SEND;
                    end else if (cnt != LAST) begin
                        cnt_nxt   = cnt + CW'(1);
                        shreg_nxt = shreg << 8;
                        state_nxt = SEND;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobe and byte are registered on entry to HDR/SEND, so tx_start is high exactly there.
    always_ff @(posedge clk or posedge rst_h) begin
        if (rst_h) begin
            state        <= IDLE;
            cnt          <= '0;
            hdr_pend     <= 1'b0;
            done_q       <= 1'b0;
            bus.tx_start <= 1'b0;
            bus.tx_data  <= 8'h00;
            overflow     <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            hdr_pend     <= hdr_pend_nxt;
            done_q       <= bus.tx_done;
            bus.tx_start <= (state_nxt == HDR) || (state_nxt == SEND);
            if (state_nxt == HDR)
                bus.tx_data <= HDR_BYTE;
            else if (state_nxt == SEND)
                bus.tx_data <= shreg_nxt[DATA_W-1 -: 8];
            if (flush)
                overflow <= 1'b0;
            else if (bus.in_valid && full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_nxt;
    end

endmodule

// File: tb/tb_result_tx_ctrl.sv
// Directed bench for result_tx_ctrl: byte scoreboard per instance plus UART done model.
module tb_result_tx_ctrl;

    logic clk = 1'b0;
    logic rst_h;
    always #5 clk = ~clk;

    logic       flush32, flush16;
    logic       busy32, busy16;
    logic [2:0] fill32, fill16;
    logic       ovf32, ovf16;

    result_tx_ctrl_if #(.DATA_W(32)) b32 ();
    result_tx_ctrl_if #(.DATA_W(16)) b16 ();

    result_tx_ctrl #(.DATA_W(32), .DEPTH(4), .HDR_EN(1'b0), .HDR_BYTE(8'hA5)) u32 (
        .clk(clk), .rst_h(rst_h), .bus(b32.slave), .flush(flush32),
        .busy(busy32), .fill_level(fill32), .overflow(ovf32)
    );

    result_tx_ctrl #(.DATA_W(16), .DEPTH(4), .HDR_EN(1'b1), .HDR_BYTE(8'hA5)) u16 (
        .clk(clk), .rst_h(rst_h), .bus(b16.slave), .flush(flush16),
        .busy(busy16), .fill_level(fill16), .overflow(ovf16)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] q32[$];
    logic [7:0] q16[$];
    int   starts32 = 0, starts16 = 0;
    int   ucnt32 = 0, ucnt16 = 0;
    logic udone32 = 1'b1, udone16 = 1'b1;
    logic prev32 = 1'b0, prev16 = 1'b0;
    logic hold32 = 1'b0;

    // UART model + scoreboard, 32-bit instance: done falls on start, rises 10 cycles later.
    always @(negedge clk) begin
        if (rst_h) begin
            udone32 = 1'b1; ucnt32 = 0; prev32 = 1'b0;
        end else begin
            if (b32.tx_start) begin
                chk("u32_no_back_to_back", prev32, 1'b0);
                chk("u32_start_expected", q32.size() != 0, 1'b1);
                if (q32.size() != 0) chk("u32_byte", b32.tx_data, q32.pop_front());
                starts32++;
                ucnt32  = 10;
                udone32 = 1'b0;
            end else if (ucnt32 > 0) begin
                ucnt32--;
                if (ucnt32 == 0) udone32 = 1'b1;
            end
            prev32 = b32.tx_start;
        end
        b32.tx_done = udone32 & ~hold32;
    end

    always @(negedge clk) begin
        if (rst_h) begin
            udone16 = 1'b1; ucnt16 = 0; prev16 = 1'b0;
        end else begin
            if (b16.tx_start) begin
                chk("u16_no_back_to_back", prev16, 1'b0);
                chk("u16_start_expected", q16.size() != 0, 1'b1);
                if (q16.size() != 0) chk("u16_byte", b16.tx_data, q16.pop_front());
                starts16++;
                ucnt16  = 10;
                udone16 = 1'b0;
            end else if (ucnt16 > 0) begin
                ucnt16--;
                if (ucnt16 == 0) udone16 = 1'b1;
            end
            prev16 = b16.tx_start;
        end
        b16.tx_done = udone16;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drain32(input int limit);
        for (int i = 0; i < limit && q32.size() != 0; i++) step();
        chk("u32_drain", q32.size(), 0);
    endtask

    task automatic push32(input logic [31:0] w, input bit expect_out);
        b32.in_data  = w;
        b32.in_valid = 1'b1;
        if (expect_out) begin
            q32.push_back(w[31:24]); q32.push_back(w[23:16]);
            q32.push_back(w[15:8]);  q32.push_back(w[7:0]);
        end
    endtask

    initial begin
        int n;
        int base;
        rst_h = 1'b1;
        b32.in_data = '0; b32.in_valid = 1'b0; flush32 = 1'b0;
        b16.in_data = '0; b16.in_valid = 1'b0; flush16 = 1'b0;
        repeat (3) step();
        rst_h = 1'b0;

        // Reset state
        chk("rst_in_ready", b32.in_ready, 1'b1);
        chk("rst_tx_start", b32.tx_start, 1'b0);
        chk("rst_tx_data", b32.tx_data, 8'h00);
        chk("rst_fill", fill32, 3'd0);
        chk("rst_overflow", ovf32, 1'b0);
        chk("rst_busy", busy32, 1'b0);
        chk("rst16_in_ready", b16.in_ready, 1'b1);
        chk("rst16_busy", busy16, 1'b0);
        step();

        // Single 32-bit word, no header
        base = starts32;
        push32(32'h11223344, 1'b1);
        step();
        b32.in_valid = 1'b0;
        chk("basic_fill", fill32, 3'd1);
        n = 1;
        while (!b32.tx_start && n < 20) begin step(); n++; end
        chk("basic_latency", n, 3);
        chk("basic_busy_mid", busy32, 1'b1);
        drain32(200);
        n = 0;
        while (!b32.tx_done && n < 50) begin step(); n++; end
        chk("basic_done_seen", b32.tx_done, 1'b1);
        chk("basic_busy_before_edge", busy32, 1'b1);
        step();
        chk("basic_busy_after_edge", busy32, 1'b0);
        chk("basic_pulses", starts32 - base, 4);

        // 16-bit word with header
        base = starts16;
        b16.in_data = 16'hBEEF; b16.in_valid = 1'b1;
        q16.push_back(8'hA5); q16.push_back(8'hBE); q16.push_back(8'hEF);
        step();
        b16.in_valid = 1'b0;
        for (int i = 0; i < 200 && q16.size() != 0; i++) step();
        chk("hdr_drain", q16.size(), 0);
        repeat (40) step();
        chk("hdr_pulses", starts16 - base, 3);
        chk("hdr_busy_end", busy16, 1'b0);

        // Overflow: six back-to-back pushes while the UART stays busy
        for (int i = 0; i < 6; i++) begin
            if (i == 2) hold32 = 1'b1;
            if (i == 4) chk("ovf_ready_i4", b32.in_ready, 1'b1);
            if (i == 5) chk("ovf_ready_i5", b32.in_ready, 1'b0);
            push32({8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i), 8'h40 + 8'(i)}, i < 5);
            step();
        end
        b32.in_valid = 1'b0;
        chk("ovf_fill_full", fill32, 3'd4);
        chk("ovf_in_ready", b32.in_ready, 1'b0);
        chk("ovf_flag", ovf32, 1'b1);
        repeat (30) step();
        chk("ovf_sticky", ovf32, 1'b1);
        chk("ovf_fill_hold", fill32, 3'd4);
        hold32 = 1'b0;
        drain32(1500);
        n = 0;
        while (busy32 && n < 50) begin step(); n++; end
        chk("ovf_busy_end", busy32, 1'b0);
        chk("ovf_sticky_end", ovf32, 1'b1);

        // Flush during byte 2 of word A with three words queued
        base = starts32;
        push32(32'hA1A2A3A4, 1'b1); step();
        push32(32'hB1B2B3B4, 1'b0); step();
        push32(32'hC1C2C3C4, 1'b0); step();
        push32(32'hD1D2D3D4, 1'b0); step();
        b32.in_valid = 1'b0;
        n = 0;
        while ((starts32 - base) < 2 && n < 100) begin step(); n++; end
        chk("flush_byte2_seen", starts32 - base, 2);
        chk("flush_fill_pre", fill32, 3'd3);
        chk("flush_ovf_pre", ovf32, 1'b1);
        flush32 = 1'b1;
        push32(32'hEEEEEEEE, 1'b0);
        step();
        flush32 = 1'b0;
        b32.in_valid = 1'b0;
        chk("flush_fill_post", fill32, 3'd0);
        chk("flush_ovf_post", ovf32, 1'b0);
        drain32(200);
        repeat (100) step();
        chk("flush_pulses", starts32 - base, 4);
        chk("flush_busy_end", busy32, 1'b0);
        chk("flush_fill_end", fill32, 3'd0);

        // Reset while waiting on byte 1
        base = starts32;
        push32(32'hCAFEF00D, 1'b0);
        q32.push_back(8'hCA);
        step();
        b32.in_valid = 1'b0;
        n = 0;
        while ((starts32 - base) < 1 && n < 50) begin step(); n++; end
        chk("rstmid_first_start", starts32 - base, 1);
        @(posedge clk);
        #2;
        chk("rstmid_busy_pre", busy32, 1'b1);
        rst_h = 1'b1;
        #1;
        chk("rstmid_tx_start", b32.tx_start, 1'b0);
        chk("rstmid_busy", busy32, 1'b0);
        chk("rstmid_fill", fill32, 3'd0);
        q32.delete();
        repeat (3) step();
        rst_h = 1'b0;
        base = starts32;
        repeat (100) step();
        chk("rstmid_quiet", starts32 - base, 0);
        chk("rstmid_busy_end", busy32, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_tx_ctrl.md
# result_tx_ctrl

Parametrised result streamer between the crypto core's result path and the UART transmitter. It buffers DATA_W-bit result words in an internal FIFO, serialises each word MSB-first into bytes with an optional frame header byte, and paces the UART with a single-cycle start strobe per byte. It replaces the fixed byte FIFO plus hand-written transmit glue at the top level, and adds overflow reporting, flush and fill-level visibility.

## Interface
- DATA_W, 128, result word width; multiple of 8, ≥8
- DEPTH, 4, FIFO depth in words; power of 2, ≥2
- HDR_EN, 1, 1 = send HDR_BYTE before every word
- HDR_BYTE, 8'hA5, frame header value
---
- clk  in  1  system clock
- rst_h  in  1  reset, asynchronous, active-high
- in_data  in  DATA_W  result word
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  FIFO can accept a word (= not full)
- flush  in  1  one-cycle synchronous flush request
- tx_start  out  1  one-cycle strobe: UART loads tx_data
- tx_data  out  8  byte to transmit, registered
- tx_done  in  1  UART level: high while transmitter idle; rising edge = byte finished
- busy  out  1  word in transmission (FSM not IDLE)
- fill_level  out  $clog2(DEPTH)+1  words stored in FIFO
- overflow  out  1  sticky: in_valid seen while full

## Operation
- Reset values: in_ready=1, tx_start=0, tx_data=8'h00, busy=0, fill_level=0, overflow=0, FSM=IDLE, done-edge register=0.
- Push: in_valid & in_ready writes in_data. in_valid & !in_ready: word dropped, overflow set.
- Push and pop in the same cycle (not full): fill_level unchanged. When full, in_ready=0, so no push that cycle even if a pop occurs.
- NB = DATA_W/8 bytes per word; byte k = word[DATA_W-1-8k -: 8], k=0..NB-1.
- FSM states:
  - IDLE: fill_level≠0 and tx_done=1 → LOAD.
  - LOAD: pop head word into shift register; clear byte counter → HDR if HDR_EN, else SEND.
  - HDR: tx_start=1, tx_data=HDR_BYTE → WAIT.
  - SEND: tx_start=1, tx_data=byte k → WAIT.
  - WAIT: on tx_done rising edge (registered previous value) → SEND with k+1 if k<NB-1, else IDLE.
- Header and data bytes share WAIT. A flag records whether the header has been sent, so the first data byte after the header is k=0.
- flush: FIFO emptied and overflow cleared in the same cycle. The word already in the shift register completes. flush has priority over a simultaneous push, and the pushed word is dropped without setting overflow.
- Reset mid-operation: all state clears asynchronously and tx_start drops immediately. The partial word is discarded.

## Timing
- Word accepted at edge E0 into an empty FIFO with tx_done=1: LOAD at E1, first tx_start high in the cycle after E2.
- tx_start is never high on two consecutive cycles. The minimum spacing is the UART's done edge plus 1 cycle (WAIT→SEND).
- fill_level updates on the edge after the push/pop. in_ready is combinational from the registered count.
- Per word: NB (+1 with header) tx_start pulses. busy stays high from LOAD until the edge leaving WAIT after the last byte.

## Structure
- Package result_tx_pkg holds the FSM state enum (IDLE, LOAD, HDR, SEND, WAIT) and the NB/counter-width constants derived from DATA_W.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH). It has write/read pointers with wrap bit, a count output and a synchronous clear used by flush.
- The serialiser FSM, done-edge detect and overflow flag live in result_tx_ctrl.

## Test plan
- Reset: hold rst_h 3 cycles → in_ready=1, tx_start=0, fill_level=0, overflow=0, busy=0.
- DATA_W=32, HDR_EN=0, push 32'h11223344, UART model raises tx_done 10 cycles after each start → tx_data 11,22,33,44, one start pulse each; busy falls after the 4th done edge.
- DATA_W=16, HDR_EN=1, HDR_BYTE=8'hA5, push 16'hBEEF → bytes A5, BE, EF in order; no 4th strobe.
- DEPTH=4, tx_done held low, push 6 words back-to-back:
  - word 1 is popped and 4 words are queued, so fill_level=4 and in_ready=0;
  - the 6th push sets overflow=1, which stays set;
  - after releasing tx_done, words 1-5 are sent in order.
- Flush while word 1's byte 2 is in flight with 3 words queued → word 1 completes all bytes; fill_level=0 next cycle; overflow cleared; no further tx_start.
- Assert rst_h during WAIT of byte 1 → tx_start=0 immediately; after release with an empty FIFO, no tx_start for 100 cycles.
